// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- registered round-robin arbiter, one-hot grant.
//
// Turns up to N level-sensitive request lines into a single registered
// one-hot grant. A grant is held while its requester keeps req high; after
// every release there is exactly one all-zero cycle before the next
// arbitration. The next search then starts just past the last winner, so
// no requester starves.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to compile in a hold counter.
// It forcibly revokes a grant after MAX_HOLD cycles and pulses timeout.
// Without the macro there is no counter and timeout is tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req[N]      in   request lines, one per requester
//   grant[N]    out  registered one-hot grant (all-zero when idle)
//   grant_valid out  registered, equals |grant
//   timeout     out  registered one-cycle pulse on forced revocation

module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // MAX_HOLD below 2 is not a supported configuration; nothing is built here.
  if (MAX_HOLD < 2) begin : g_max_hold_illegal
  end

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic           found_s;
  logic [PW-1:0]  winner_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  // Round-robin search: first set req bit at ptr+1, ptr+2, ... modulo N.
  always_comb begin
    found_s  = 1'b0;
    winner_s = ptr_q;
    for (int i = 1; i <= N; i++) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found_s && req[idx]) begin
        found_s  = 1'b1;
        winner_s = idx;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic of the IDLE/GRANT controller.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d       = onehot(winner_s);
          grant_valid_d = 1'b1;
          ptr_d         = winner_s;
          state_d       = S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d    = {HW{1'b0}};
`endif
        end else begin
          grant_d       = {N{1'b0}};
          grant_valid_d = 1'b0;
        end
      end
      S_GRANT: begin
        // Release has priority over revocation on the same edge.
        if (!req[ptr_q]) begin
          grant_d       = {N{1'b0}};
          grant_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
            grant_d       = {N{1'b0}};
            grant_valid_d = 1'b0;
            timeout_d     = 1'b1;
            state_d       = S_IDLE;
          end else begin
            hold_cnt_d    = hold_cnt_q + HW'(1);
          end
`else
          state_d = S_GRANT;
`endif
        end
      end
      default: begin
        grant_d       = {N{1'b0}};
        grant_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers; ptr resets to N-1 so the first search starts at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= PW'(N - 1);
      grant_q       <= {N{1'b0}};
      grant_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q    <= {HW{1'b0}};
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus randomized
// request traffic, all compared against a cycle-level behavioural model.
// The arbiter is built with MAX_HOLD=4 so the timeout scenario is short when
// RR_ARB_TIMEOUT_EN is defined.

module tb_rr_arbiter_8;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the grant (-1 = nobody), last winner,
  // cycles the current grant has been visible, and the timeout pulse.
  int m_owner;
  int m_last;
  int m_held;
  bit m_to;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  // One rising edge of the arbiter, seen from the specification's rules.
  function automatic void model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int cand;
        cand = (m_last + k) % N;
        if (m_owner < 0 && r[cand]) begin
          m_owner = cand;
          m_last  = cand;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TO_EN && m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [7:0] model_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  // Drive req, take one edge, advance the model, compare all outputs.
  task automatic step(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_value({tag, ".grant"}, {24'd0, grant}, {24'd0, model_grant()});
    check_value({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, (m_owner >= 0)});
    check_value({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
  endtask

  // Asynchronous reset away from any clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_value({tag, ".rst_grant"}, {24'd0, grant}, 32'd0);
    check_value({tag, ".rst_valid"}, {31'd0, grant_valid}, 32'd0);
    check_value({tag, ".rst_timeout"}, {31'd0, timeout}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    #3;
    check_value("init.grant", {24'd0, grant}, 32'd0);
    check_value("init.valid", {31'd0, grant_valid}, 32'd0);
    check_value("init.timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 3; i++) step(8'h00, "idle");

    // Single requester, then drop it.
    step(8'h04, "single");
    check_value("single.on", {24'd0, grant}, 32'h04);
    step(8'h00, "single_drop");
    check_value("single.off", {24'd0, grant}, 32'h00);
    step(8'h00, "single_stay");

    // Rotation between requesters 0 and 7.
    async_reset("rot");
    step(8'h81, "rot");
    check_value("rot.first", {24'd0, grant}, 32'h01);
    step(8'h80, "rot_drop0");
    check_value("rot.bubble0", {24'd0, grant}, 32'h00);
    step(8'h81, "rot_re0");
    check_value("rot.second", {24'd0, grant}, 32'h80);
    step(8'h01, "rot_drop7");
    check_value("rot.bubble7", {24'd0, grant}, 32'h00);
    step(8'h01, "rot_third");
    check_value("rot.third", {24'd0, grant}, 32'h01);

    // Full round with every requester active.
    async_reset("round");
    for (int i = 0; i <= N; i++) begin
      r = 8'h00;
      r[i % N] = 1'b1;
      step(8'hFF, "round");
      check_value("round.grant", {24'd0, grant}, {24'd0, r});
      step(8'hFF & ~r, "round_drop");
      check_value("round.bubble", {24'd0, grant}, 32'h00);
    end

    // Grant stability while other requests toggle.
    async_reset("stab");
    step(8'h08, "stab");
    for (int i = 0; i < 10; i++) begin
      r = (i % 2 == 0) ? 8'hA5 : 8'h52;
      step(r | 8'h08, "stab_toggle");
      check_value("stab.hold", {24'd0, grant}, 32'h08);
    end
    step(8'h00, "stab_end");

    // Long hold: forced revocation with the timeout, unbounded without it.
    async_reset("hold");
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(8'h10, "to_hold");
      check_value("to.held", {24'd0, grant}, 32'h10);
    end
    step(8'h10, "to_revoke");
    check_value("to.revoked", {24'd0, grant}, 32'h00);
    check_value("to.pulse", {31'd0, timeout}, 32'd1);
    step(8'h10, "to_regrant");
    check_value("to.regrant", {24'd0, grant}, 32'h10);
    check_value("to.pulse_end", {31'd0, timeout}, 32'd0);
`else
    for (int i = 0; i < 55; i++) begin
      step(8'h10, "hold");
      check_value("hold.grant", {24'd0, grant}, 32'h10);
      check_value("hold.no_timeout", {31'd0, timeout}, 32'd0);
    end
`endif
    step(8'h00, "hold_end");

    // Randomized traffic: requests tend to persist, new ones appear sparsely.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r = (r & ($urandom() | $urandom())) | ($urandom() & $urandom() & $urandom());
      step(r, "rand");
    end

    // Reset in the middle of a grant with every request high.
    step(8'hFF, "midrst_pre");
    step(8'hFF, "midrst_pre2");
    async_reset("midrst");
    step(8'hFF, "midrst_after");
    check_value("midrst.first", {24'd0, grant}, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Registered round-robin arbiter that turns up to N concurrent request lines into a single one-hot grant vector. It sits directly upstream of the 8-to-3 encoder, which converts `grant` into a binary index for the datapath select. Each grant is held while its requester keeps `req` high. Priority then rotates so that no requester starves. An optional hold timeout forcibly revokes grants that are held too long.

## Interface
- `N`, default 8: number of requesters; the downstream encoder requires 8.
- `MAX_HOLD`, default 16: maximum grant length in cycles, used only when the timeout is compiled in; legal range ≥2.
- `clk` input, 1 bit: single clock, rising-edge active.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req` input, N bits: request lines, level-sensitive, one per requester.
- `grant` output, N bits: registered one-hot grant, or all-zero when nothing is granted.
- `grant_valid` output, 1 bit: registered; equals `|grant`.
- `timeout` output, 1 bit: registered one-cycle pulse on forced revocation; constant 0 when the timeout is compiled out.

## Operation
- Two-state FSM: IDLE and GRANT.
- State registers:
  - `ptr`, $clog2(N) bits: index of the last winner.
  - `hold_cnt`, $clog2(MAX_HOLD) bits: present only with the timeout.
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE, `grant`=0, `grant_valid`=0, `timeout`=0.
  - `ptr`=N-1, so the first search starts at bit 0.
  - `hold_cnt`=0.
- IDLE, at a rising edge:
  - If `req`==0, stay in IDLE; outputs stay 0.
  - Otherwise the winner is the first set bit of `req` scanning `ptr`+1, `ptr`+2, … modulo N (wrap from N-1 to 0).
  - Then `grant`<=onehot(winner), `grant_valid`<=1, `ptr`<=winner, `hold_cnt`<=0, state<=GRANT.
- GRANT, at a rising edge:
  - If `req[ptr]`==0, the grant is released: `grant`<=0, `grant_valid`<=0, state<=IDLE.
  - Other `req` bits are ignored while in GRANT. Their changes never alter `grant`.
  - Otherwise, with the timeout compiled in, `hold_cnt` increments each cycle.
- Bubble rule:
  - Every release or revocation is followed by exactly one IDLE cycle with `grant`=0.
  - Arbitration happens on the edge after that cycle.
  - The downstream encoder therefore never sees two grants back-to-back.
- `ptr` is updated only on a new grant. Release and revocation leave it unchanged.
- A requester that re-asserts immediately after release has the lowest priority in the next round, unless it is the only requester.

## Timing
- Latency from request to grant:
  - `req` is high before edge k while in IDLE.
  - `grant` is visible after edge k.
  - That is one cycle, measured from the first sampling edge.
- Release latency:
  - `req[ptr]` falls before edge k.
  - `grant` is 0 after edge k.
  - The earliest new grant is after edge k+1.
- All outputs are registered. There is no combinational path from `req` to any output.
- Reset in mid-GRANT:
  - `grant` clears immediately (asynchronously).
  - `ptr` returns to N-1.
  - The first edge after `rst_n` rises re-arbitrates from bit 0.
- Simultaneous release and timeout on the same edge: release wins and `timeout` stays 0.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` exists.
  - In GRANT, if `req[ptr]`==1 and `hold_cnt`==MAX_HOLD-1, the grant is revoked at that edge: `grant`<=0, `grant_valid`<=0, `timeout`<=1 for one cycle, state<=IDLE.
  - The grant therefore lasts exactly MAX_HOLD cycles.
  - The revoked requester loses priority per the `ptr` rule.
- Undefined:
  - No counter exists.
  - A grant is held for as long as its `req` stays high.
  - `timeout` is tied to 0.

## Test plan
- Reset check: assert `rst_n`=0 mid-simulation with `req`=8'hFF → `grant`=0, `grant_valid`=0 and `timeout`=0 immediately, without waiting for `clk`. After release, the first grant is 8'b00000001.
- Single requester: `req`=8'b00000100 → `grant`=8'b00000100 one cycle later. Drop `req` → `grant`=0 on the next edge, and it stays 0.
- Rotation: hold `req`=8'b10000001. The sequence is:
  - `grant`=8'b00000001 first.
  - Drop bit 0 for one cycle, then re-raise it → one cycle of `grant`=0, then `grant`=8'b10000000.
  - Drop bit 7 → one cycle of `grant`=0, then `grant`=8'b00000001.
- Full round: `req`=8'hFF, with each granted requester dropping its `req` for one cycle after one cycle of grant → grants cycle 0x01, 0x02, … 0x80, 0x01, with one zero bubble between each.
- Grant stability: with `grant`=8'b00001000 held, toggle every other `req` bit each cycle → `grant` stays 8'b00001000 unchanged.
- Timeout (`RR_ARB_TIMEOUT_EN`, `MAX_HOLD`=4): hold `req`=8'b00010000 → `grant` is high for exactly 4 cycles, then `grant`=0 with `timeout`=1 for one cycle, then `grant`=8'b00010000 again. Without the macro, `grant` stays high for 50+ cycles and `timeout` never rises.
